attempt_lockout_ctrl: RTL and testbench



---
 rtl/attempt_lockout_ctrl.sv | 120 ++++++++++++
 tb/tb_attempt_lockout_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/attempt_lockout_ctrl.sv
// Sequences the button sequence detector: gates enter, holds the pass/fail result,
// clears the detector and locks it out after MAX_FAILS consecutive failures.
// state   | meaning
// IDLE    | detector armed, enter passed through, waiting for blue/red
// SHOW    | result displayed for HOLD_CYCLES
// CLEAR   | det_clr_n low until min time elapsed and blue/red both low
// LOCKOUT | detector held cleared for LOCK_CYCLES
module attempt_lockout_ctrl #(
  parameter int HOLD_CYCLES = 125000000,
  parameter int CLR_CYCLES  = 16,
  parameter int LOCK_CYCLES = 1250000000,
  parameter int MAX_FAILS   = 3,
  parameter int CNT_W       = 32
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       enter_in,
  input  logic       blue,
  input  logic       red,
  output logic       enter_out,
  output logic       det_clr_n,
  output logic       locked,
  output logic [1:0] fail_cnt
);

  typedef enum logic [1:0] {IDLE, SHOW, CLEAR, LOCKOUT} state_e;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLR_LAST  = CNT_W'(CLR_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [1:0]       MAX_F     = 2'(MAX_FAILS);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [1:0]       fail_q, fail_d;
  logic             enter_q, enter_d;
  logic             clr_n_q, clr_n_d;
  logic             locked_q, locked_d;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    fail_d  = fail_q;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (red) begin
          fail_d  = (fail_q == MAX_F) ? fail_q : fail_q + 2'd1;
          state_d = SHOW;
        end else if (blue) begin
          fail_d  = 2'd0;
          state_d = SHOW;
        end
      end
      SHOW: begin
        if (timer_q == HOLD_LAST) begin
          state_d = CLEAR;
          timer_d = '0;
        end else begin
          timer_d = timer_q + CNT_ONE;
        end
      end
      CLEAR: begin
        // Timer parks at its last value while the detector still reports a result.
        if (timer_q >= CLR_LAST) begin
          if (!blue && !red) begin
            state_d = (fail_q == MAX_F) ? LOCKOUT : IDLE;
            timer_d = '0;
          end
        end else begin
          timer_d = timer_q + CNT_ONE;
        end
      end
      LOCKOUT: begin
        if (timer_q == LOCK_LAST) begin
          state_d = IDLE;
          timer_d = '0;
          fail_d  = 2'd0;
        end else begin
          timer_d = timer_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase

    // Outputs are decoded from the next state so they line up with state_q.
    // Enter only passes on IDLE->IDLE, so it reappears one cycle after IDLE entry.
    enter_d  = enter_in && (state_q == IDLE) && (state_d == IDLE);
    clr_n_d  = (state_d == IDLE) || (state_d == SHOW);
    locked_d = (state_d == LOCKOUT);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      fail_q   <= 2'd0;
      enter_q  <= 1'b0;
      clr_n_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      fail_q   <= fail_d;
      enter_q  <= enter_d;
      clr_n_q  <= clr_n_d;
      locked_q <= locked_d;
    end
  end

  assign enter_out = enter_q;
  assign det_clr_n = clr_n_q;
  assign locked    = locked_q;
  assign fail_cnt  = fail_q;

endmodule

// File: tb/tb_attempt_lockout_ctrl.sv
// Random stimulus against a countdown-based reference model of the lockout controller.
module tb_attempt_lockout_ctrl;

  localparam int HOLD   = 10;
  localparam int CLRC   = 4;
  localparam int LOCK   = 50;
  localparam int MAXF   = 3;
  localparam int CYCLES = 6000;

  logic       clk = 1'b0;
  logic       clr, enter_in, blue, red;
  logic       enter_out, det_clr_n, locked;
  logic [1:0] fail_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  attempt_lockout_ctrl #(
    .HOLD_CYCLES(HOLD),
    .CLR_CYCLES (CLRC),
    .LOCK_CYCLES(LOCK),
    .MAX_FAILS  (MAXF),
    .CNT_W      (32)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .enter_in (enter_in),
    .blue     (blue),
    .red      (red),
    .enter_out(enter_out),
    .det_clr_n(det_clr_n),
    .locked   (locked),
    .fail_cnt (fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Reference model: remaining display cycles, clear cycles spent, remaining lockout cycles.
  int show_left = 0;
  int clr_spent = 0;
  int lock_left = 0;
  int m_fail    = 0;
  bit clearing  = 1'b0;
  bit m_ent     = 1'b0;
  bit last_rst  = 1'b0;
  int n_lock    = 0;

  function automatic bit m_idle();
    return (show_left == 0) && !clearing && (lock_left == 0);
  endfunction

  task automatic model_step();
    bit was_idle;
    if (clr) begin
      show_left = 0;
      clr_spent = 0;
      lock_left = 0;
      m_fail    = 0;
      clearing  = 1'b0;
      m_ent     = 1'b0;
      last_rst  = 1'b1;
    end else begin
      last_rst = 1'b0;
      was_idle = m_idle();
      if (was_idle) begin
        if (red) begin
          m_fail    = (m_fail < MAXF) ? m_fail + 1 : MAXF;
          show_left = HOLD;
        end else if (blue) begin
          m_fail    = 0;
          show_left = HOLD;
        end
      end else if (show_left > 0) begin
        show_left--;
        if (show_left == 0) begin
          clearing  = 1'b1;
          clr_spent = 0;
        end
      end else if (clearing) begin
        clr_spent++;
        if (clr_spent >= CLRC && !blue && !red) begin
          clearing = 1'b0;
          if (m_fail == MAXF) begin
            lock_left = LOCK;
            n_lock++;
          end
        end
      end else begin
        lock_left--;
        if (lock_left == 0) m_fail = 0;
      end
      m_ent = was_idle && m_idle() && enter_in;
    end
  endtask

  initial begin
    bit lock_rst_done = 1'b0;
    clr      = 1'b1;
    enter_in = 1'b0;
    blue     = 1'b0;
    red      = 1'b0;
    model_step();
    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      @(negedge clk);
      check("enter_out", int'(enter_out), int'(m_ent));
      check("det_clr_n", int'(det_clr_n), int'(!last_rst && (m_idle() || show_left > 0)));
      check("locked",    int'(locked),    int'(lock_left > 0));
      check("fail_cnt",  int'(fail_cnt),  m_fail);

      if (cyc < 3) begin
        clr = 1'b1;
      end else if (n_lock == 2 && lock_left == LOCK - 19 && !lock_rst_done) begin
        clr = 1'b1;
        lock_rst_done = 1'b1;
      end else begin
        clr = ($urandom_range(0, 499) == 0);
      end
      if ($urandom_range(0, 5) == 0) enter_in = ~enter_in;
      if (blue) blue = ($urandom_range(0, 2) != 0);
      else      blue = ($urandom_range(0, 11) == 0);
      if (red)  red  = ($urandom_range(0, 2) != 0);
      else      red  = ($urandom_range(0, 9) == 0);
      model_step();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
